// File: rtl/char_rx.sv
// rtl/char_rx.sv - serial character receiver, 1 start / 8 data MSB first / 1 stop
//
// Ports:
//   i_clk        sample clock (23.04 MHz)
//   i_rst        asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   i_baud       baud code, latched when a start bit is detected
//   o_char       last good byte, held until the next good frame
//   o_valid      one-cycle strobe, o_char updated
//   o_frame_err  one-cycle strobe, stop bit sampled low
//   o_busy       high whenever the receiver is not idle
//
// Build option CHAR_RX_MAJORITY_EN: each start/data/stop sample is the 2-of-3
// majority around the nominal sample cycle, with the decision one cycle later.

module char_rx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic [2:0] i_baud,
  output logic [7:0] o_char,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] period_q, period_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  char_q, char_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q;
  logic        sync1_q, rx_s_q;

  logic [12:0] baud_period;
  logic        smp;
  logic        start_hit;
  logic        bit_hit;

  // Bit period in sample-clock cycles for each baud code.
  always_comb begin
    baud_period = 13'd4800;
    case (i_baud)
      3'd0:    baud_period = 13'd100;
      3'd1:    baud_period = 13'd200;
      3'd2:    baud_period = 13'd400;
      3'd3:    baud_period = 13'd600;
      3'd4:    baud_period = 13'd1200;
      3'd5:    baud_period = 13'd2400;
      default: baud_period = 13'd4800;
    endcase
  end

`ifdef CHAR_RX_MAJORITY_EN
  logic rx_d1_q, rx_d2_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_d1_q <= 1'b1;
      rx_d2_q <= 1'b1;
    end else begin
      rx_d1_q <= rx_s_q;
      rx_d2_q <= rx_d1_q;
    end
  end

  // Decision cycle is one after the nominal sample, so the window is
  // {nominal-1, nominal, nominal+1} = {rx_d2, rx_d1, rx_s}. The start decision
  // waits for counter==H; since the counter restarts one cycle late after each
  // decision, data/stop decisions still land on counter==P-1.
  assign smp       = (rx_s_q & rx_d1_q) | (rx_s_q & rx_d2_q) | (rx_d1_q & rx_d2_q);
  assign start_hit = (cnt_q == (period_q >> 1));
  assign bit_hit   = (cnt_q == (period_q - 13'd1));
`else
  assign smp       = rx_s_q;
  assign start_hit = (cnt_q == ((period_q >> 1) - 13'd1));
  assign bit_hit   = (cnt_q == (period_q - 13'd1));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 13'd1;
    period_d = period_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    char_d   = char_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          period_d = baud_period;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (start_hit) begin
          cnt_d = '0;
          if (!smp) begin
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            // Line went back high before mid-start: glitch, not a frame.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (bit_hit) begin
          cnt_d = '0;
          sr_d  = {sr_q[6:0], smp};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (bit_hit) begin
          cnt_d = '0;
          if (smp) begin
            char_d  = sr_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end

      S_WAIT_HIGH: begin
        // Hold off through a break so a held-low line is not taken as a start.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q  <= i_rx;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign o_char      = char_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule
